// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared memory port
// Data wins ties until STARVE_LIMIT grants pass while a fetch waits; stuck accesses time out.
module mem_arbiter #(
   parameter int MAX_WAIT     = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic [SW-1:0] starve_cnt;
   logic          starve_full;
   logic          timeout;

   assign starve_full = (starve_cnt == SW'(STARVE_LIMIT));
   // Last permitted unacknowledged cycle: leave BUSY on this edge.
   assign timeout     = !mem_ack && (wait_cnt == WW'(MAX_WAIT - 1));

   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         err        <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         if_ready   <= 1'b0;
         dm_ready   <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (dm_req && !starve_full) begin
                  state     <= BUSY_D;
                  mem_valid <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  if (if_req) starve_cnt <= starve_cnt + 1'b1;
               end else if (if_req) begin
                  state      <= BUSY_I;
                  mem_valid  <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  starve_cnt <= '0;
               end
               if (!if_req) starve_cnt <= '0;
            end
            BUSY_I, BUSY_D: begin
               if (mem_ack || timeout) begin
                  mem_valid <= 1'b0;
                  if (!mem_ack) err <= 1'b1;
                  if (state == BUSY_I) begin
                     state    <= RESP_I;
                     if_ready <= 1'b1;
                     if_rdata <= mem_ack ? mem_rdata : 32'h0;
                  end else begin
                     state    <= RESP_D;
                     dm_ready <= 1'b1;
                     if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : 32'h0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scenarios plus randomized run against a cycle reference model
module tb_mem_arbiter;
   localparam int MAX_WAIT     = 16;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ready, dm_ready, mem_valid, mem_we, stall_if, stall_mem, err;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; if_req = 1; dm_req = 1; dm_we = 1; if_addr = 32'h44; dm_addr = 32'h88;
      dm_wdata = 32'h5; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      checks++; if ({mem_valid, mem_we, if_ready, dm_ready, err} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=00000", {mem_valid, mem_we, if_ready, dm_ready, err}); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
      checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got if=%h dm=%h want 0", if_rdata, dm_rdata); end
      checks++; if ({stall_if, stall_mem} !== 2'b11) begin failures++; $display("FAIL reset_stall got=%b want=11", {stall_if, stall_mem}); end
      do_reset();
   endtask

   task automatic test_fetch();
      do_reset();
      if_req = 1; if_addr = 32'h10;
      @(negedge clk);
      checks++; if ({mem_valid, mem_we, if_ready, stall_if} !== 4'b1001) begin failures++; $display("FAIL fetch_busy got=%b want=1001", {mem_valid, mem_we, if_ready, stall_if}); end
      checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL fetch_addr got=%h want=00000010", mem_addr); end
      mem_ack = 1; mem_rdata = 32'h0050_0113;
      @(negedge clk);
      checks++; if ({mem_valid, if_ready, stall_if} !== 3'b010) begin failures++; $display("FAIL fetch_resp got=%b want=010", {mem_valid, if_ready, stall_if}); end
      checks++; if (if_rdata !== 32'h0050_0113) begin failures++; $display("FAIL fetch_rdata got=%h want=00500113", if_rdata); end
      mem_ack = 0; if_req = 0;
      @(negedge clk);
      checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_width got=%b want=0", if_ready); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h60;
      @(negedge clk);
      checks++; if ({mem_valid, mem_we, stall_if} !== 3'b101 || mem_addr !== 32'h60) begin failures++; $display("FAIL simul_data_first got v/we/st=%b addr=%h want 101/00000060", {mem_valid, mem_we, stall_if}, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h0000_CAFE;
      @(negedge clk);
      checks++; if ({dm_ready, if_ready, stall_if} !== 3'b101 || dm_rdata !== 32'hCAFE) begin failures++; $display("FAIL simul_data_resp got rdy/st=%b rdata=%h want 101/0000cafe", {dm_ready, if_ready, stall_if}, dm_rdata); end
      mem_ack = 0; dm_req = 0;
      @(negedge clk);
      checks++; if ({mem_valid, stall_if} !== 2'b01) begin failures++; $display("FAIL simul_gap got=%b want=01", {mem_valid, stall_if}); end
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h20) begin failures++; $display("FAIL simul_fetch_grant got v=%b addr=%h want 1/00000020", mem_valid, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h11;
      @(negedge clk);
      checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h11) begin failures++; $display("FAIL simul_fetch_resp got rdy=%b rdata=%h want 1/00000011", if_ready, if_rdata); end
      mem_ack = 0; if_req = 0;
      @(negedge clk);
   endtask

   task automatic test_starvation();
      int  n = 0;
      logic is_fetch;
      do_reset();
      if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
      for (int c = 0; c < 40 && n < 10; c++) begin
         @(negedge clk);
         if (mem_valid) begin
            is_fetch = (mem_addr == 32'h100);
            checks++; if (is_fetch !== (n == 4 || n == 9)) begin failures++; $display("FAIL starve_order grant=%0d got fetch=%b want=%b", n, is_fetch, (n == 4 || n == 9)); end
            if (!is_fetch) begin
               checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL starve_stall_if grant=%0d got=%b want=1", n, stall_if); end
            end
            mem_ack = 1; n++;
         end else mem_ack = 0;
      end
      checks++; if (n != 10) begin failures++; $display("FAIL starve_grants got=%0d want=10", n); end
      @(negedge clk);
      mem_ack = 0; if_req = 0; dm_req = 0;
      @(negedge clk);
   endtask

   task automatic test_store();
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 32'h64;
      @(negedge clk);
      mem_ack = 1; mem_rdata = 32'h1234;
      @(negedge clk);
      checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h1234) begin failures++; $display("FAIL store_preload got rdy=%b rdata=%h want 1/00001234", dm_ready, dm_rdata); end
      mem_ack = 0; dm_we = 1; dm_wdata = 32'hA;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if ({mem_valid, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h64, 32'hA}) begin failures++; $display("FAIL store_hold cyc=%0d got v=%b we=%b addr=%h wdata=%h want 1/1/00000064/0000000a", i, mem_valid, mem_we, mem_addr, mem_wdata); end
         if (i == 1) begin dm_addr = 32'h999; dm_wdata = 32'hBAD; end
         mem_ack = (i == 3);
      end
      @(negedge clk);
      checks++; if ({dm_ready, mem_valid} !== 2'b10 || dm_rdata !== 32'h1234) begin failures++; $display("FAIL store_resp got rdy/v=%b rdata=%h want 10/00001234", {dm_ready, mem_valid}, dm_rdata); end
      mem_ack = 0; dm_req = 0;
      @(negedge clk);
      checks++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL store_ready_width got=%b want=0", dm_ready); end
   endtask

   task automatic test_timeout();
      int   vcnt = 0;
      logic seen = 0;
      do_reset();
      if_req = 1; if_addr = 32'h40;
      @(negedge clk);
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (if_rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin failures++; $display("FAIL timeout_pre got rdata=%h err=%b want deadbeef/0", if_rdata, err); end
      mem_ack = 0; if_addr = 32'h44;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         if (mem_valid) vcnt++;
         if (if_ready) begin
            seen = 1;
            checks++; if (if_rdata !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL timeout_resp got rdata=%h err=%b want 00000000/1", if_rdata, err); end
         end
      end
      checks++; if (!seen || vcnt != MAX_WAIT) begin failures++; $display("FAIL timeout_len got seen=%b valid_cycles=%0d want 1/%0d", seen, vcnt, MAX_WAIT); end
      if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h70;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h70) begin failures++; $display("FAIL timeout_next_grant got v=%b addr=%h want 1/00000070", mem_valid, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h55;
      @(negedge clk);
      checks++; if ({dm_ready, err} !== 2'b11 || dm_rdata !== 32'h55) begin failures++; $display("FAIL timeout_next_resp got rdy/err=%b rdata=%h want 11/00000055", {dm_ready, err}, dm_rdata); end
      mem_ack = 0; dm_req = 0;
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 32'h80;
      repeat (MAX_WAIT + 3) @(negedge clk);
      checks++; if ({err, mem_valid} !== 2'b11) begin failures++; $display("FAIL midrst_pre got err/v=%b want 11", {err, mem_valid}); end
      reset = 0;
      @(negedge clk);
      checks++; if ({mem_valid, dm_ready, err, stall_mem} !== 4'b0001) begin failures++; $display("FAIL midrst_abort got v/rdy/err/st=%b want 0001", {mem_valid, dm_ready, err, stall_mem}); end
      reset = 1;
      @(negedge clk);
      checks++; if ({mem_valid, dm_ready} !== 2'b10) begin failures++; $display("FAIL midrst_idle_regrant got v/rdy=%b want 10", {mem_valid, dm_ready}); end
      mem_ack = 1; dm_req = 0;
      @(negedge clk);
      checks++; if (dm_ready !== 1'b1) begin failures++; $display("FAIL midrst_resume got=%b want=1", dm_ready); end
      mem_ack = 0;
      @(negedge clk);
   endtask

   // Reference model: owner of the memory port (0 none, 1 fetch, 2 data) and of the ready pulse.
   task automatic test_random();
      int          busy = 0, resp = 0, wait_n = 0, starve = 0, target = 0, nb, nr;
      logic        t_we = 0, m_err = 0;
      logic [31:0] t_addr = 0, t_wdata = 0, m_if = 0, m_dm = 0;
      logic        p_if_req, p_dm_req, p_we, p_ack;
      logic [31:0] p_if_addr, p_dm_addr, p_wdata, p_rdata;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         p_if_req = if_req; p_dm_req = dm_req; p_we = dm_we; p_ack = mem_ack;
         p_if_addr = if_addr; p_dm_addr = dm_addr; p_wdata = dm_wdata; p_rdata = mem_rdata;
         @(negedge clk);
         nb = 0; nr = 0;
         if (busy != 0) begin
            if (p_ack || wait_n + 1 == MAX_WAIT) begin
               nr = busy;
               if (!p_ack) m_err = 1;
               if (busy == 1) m_if = p_ack ? p_rdata : 32'h0;
               else if (!t_we) m_dm = p_ack ? p_rdata : 32'h0;
            end else begin
               nb = busy; wait_n++;
            end
         end else if (resp == 0) begin
            wait_n = 0;
            if (p_dm_req && starve < STARVE_LIMIT) begin
               nb = 2; t_we = p_we; t_addr = p_dm_addr; t_wdata = p_wdata;
               if (p_if_req) starve++;
            end else if (p_if_req) begin
               nb = 1; t_we = 0; t_addr = p_if_addr; starve = 0;
            end
            if (!p_if_req) starve = 0;
            if (nb != 0) target = ($urandom_range(0, 15) == 0) ? MAX_WAIT + 2 : int'($urandom_range(0, 3));
         end
         busy = nb; resp = nr;
         checks++; if (mem_valid !== (busy != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, mem_valid, (busy != 0)); end
         if (busy != 0) begin
            checks++; if (mem_addr !== t_addr || mem_we !== t_we) begin failures++; $display("FAIL rnd_cmd cyc=%0d got addr=%h we=%b want %h/%b", cyc, mem_addr, mem_we, t_addr, t_we); end
            if (busy == 2) begin
               checks++; if (mem_wdata !== t_wdata) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, mem_wdata, t_wdata); end
            end
         end
         checks++; if ({if_ready, dm_ready} !== {resp == 1, resp == 2}) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, {if_ready, dm_ready}, {resp == 1, resp == 2}); end
         checks++; if (if_rdata !== m_if || dm_rdata !== m_dm) begin failures++; $display("FAIL rnd_rdata cyc=%0d got if=%h dm=%h want %h/%h", cyc, if_rdata, dm_rdata, m_if, m_dm); end
         checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, err, m_err); end
         checks++; if ({stall_if, stall_mem} !== {p_if_req & (resp != 1), p_dm_req & (resp != 2)}) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", cyc, {stall_if, stall_mem}, {p_if_req & (resp != 1), p_dm_req & (resp != 2)}); end
         if (resp == 1) if_req = ($urandom_range(0, 1) == 1);
         else if (!if_req) if_req = ($urandom_range(0, 3) == 0);
         if (resp == 2) dm_req = ($urandom_range(0, 3) != 0);
         else if (!dm_req) dm_req = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 2) == 0) begin
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; dm_we = ($urandom_range(0, 1) == 1);
         end
         mem_ack = (busy != 0) ? (wait_n >= target) : ($urandom_range(0, 1) == 1);
         mem_rdata = $urandom;
      end
      if_req = 0; dm_req = 0; mem_ack = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_simultaneous();
      test_starvation();
      test_store();
      test_timeout();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
